// File: rtl/mac8_seq_ctrl.sv
// Sequential sum-of-products engine: one signed WxW multiplier shared across N
// operand pairs, each with its own pre-op, accumulated modulo 2^OW.
module mac8_seq_ctrl #(
    parameter int W  = 6,
    parameter int N  = 8,
    parameter int OW = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N*W-1:0]    in_a,
    input  logic [N*W-1:0]    in_b,
    input  logic [N*3-1:0]    op_sel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OW-1:0]     out_q,
    output logic              busy
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [N*W-1:0]    a_q, a_d;
    logic [N*W-1:0]    b_q, b_d;
    logic [N*3-1:0]    op_q, op_d;
    logic [OW-1:0]     acc_q, acc_d;
    logic [OW-1:0]     res_q, res_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              ready_en_q, ready_en_d;

    logic [W-1:0]          cur_a, cur_b;
    logic [2:0]            cur_op;
    logic [W-1:0]          pre_a, pre_b;
    logic signed [2*W-1:0] prod;
    logic [OW-1:0]         prod_ext;

    function automatic logic [W-1:0] pre_op(input logic [W-1:0] x, input logic [2:0] op);
        logic [W-1:0] r;
        case (op)
            3'd1:    r = ~x;
            3'd2:    r = -x;
            3'd3:    r = W'($signed(x) >>> 4);
            3'd4:    r = x << 4;
            3'd5:    r = {W{x[0]}};
            default: r = x;
        endcase
        return r;
    endfunction

    assign cur_a  = a_q[int'(idx_q)*W +: W];
    assign cur_b  = b_q[int'(idx_q)*W +: W];
    assign cur_op = op_q[int'(idx_q)*3 +: 3];
    assign pre_a  = pre_op(cur_a, cur_op);
    assign pre_b  = pre_op(cur_b, cur_op);
    assign prod   = $signed(pre_a) * $signed(pre_b);
    // Size cast sign-extends or truncates the product into the accumulator width.
    assign prod_ext = OW'(prod);

    // Ready stays low until the first clock after reset release.
    assign in_ready  = (state_q == IDLE) && ready_en_q;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_q     = res_q;

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        acc_d      = acc_q;
        idx_d      = idx_q;
        res_d      = res_q;
        ready_en_d = 1'b1;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    op_d    = op_sel;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_q + prod_ext;
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    res_d   = acc_q + prod_ext;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            acc_q      <= '0;
            res_q      <= '0;
            idx_q      <= '0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            acc_q      <= acc_d;
            res_q      <= res_d;
            idx_q      <= idx_d;
            ready_en_q <= ready_en_d;
        end
    end

endmodule

// File: tb/tb_mac8_seq_ctrl.sv
// Scoreboard bench for mac8_seq_ctrl: the driver pushes model results at
// acceptance, an independent monitor pops and compares when a result is offered.
module tb_mac8_seq_ctrl;

   localparam int W  = 6;
   localparam int N  = 8;
   localparam int OW = 9;

   typedef struct {
      logic [OW-1:0] res;
      int            accEdge;
   } exp_t;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [N*W-1:0]   in_a;
   logic [N*W-1:0]   in_b;
   logic [N*3-1:0]   op_sel;
   logic             out_valid;
   logic             out_ready;
   logic [OW-1:0]    out_q;
   logic             busy;

   logic [N*W-1:0]   ja, jb;
   logic [N*3-1:0]   jo;
   exp_t             expQ[$];
   int               cycleCnt;
   int               nChecks;
   int               nPassed;
   bit               randMode;
   bit               forcedReady;

   mac8_seq_ctrl #(.W(W), .N(N), .OW(OW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .op_sel    (op_sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_q     (out_q),
      .busy      (busy)
   );

   // Free-running clock with posedges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Edge counter used to measure acceptance-to-result latency and job spacing.
   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   // Consumer side: either random backpressure or a level chosen by the main sequence.
   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         out_ready = randMode ? ($urandom_range(0, 3) != 0) : forcedReady;
      end
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      nChecks++;
      if (actual == expected) nPassed++;
      else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
   endtask

   task automatic reportTimeout(input string name);
      nChecks++;
      $display("[TB] FAIL %s: timed out waiting on DUT (t=%0t)", name, $time);
   endtask

   // Reference model: plain integer arithmetic on signed operand values.
   function automatic int sx6(input logic [W-1:0] x);
      int v;
      v = int'(x);
      if (v >= 32) v -= 64;
      return v;
   endfunction

   function automatic int wrapSigned(input int v, input int bits);
      int m;
      int r;
      m = 1 << bits;
      r = v % m;
      if (r < 0) r += m;
      if (r >= m / 2) r -= m;
      return r;
   endfunction

   function automatic int modelPre(input int v, input int op);
      int r;
      case (op)
         1: return -v - 1;
         2: return wrapSigned(-v, W);
         3: begin
            r = v % 16;
            if (r < 0) r += 16;
            return (v - r) / 16;
         end
         4: return wrapSigned(v * 16, W);
         5: return (v % 2 != 0) ? -1 : 0;
         default: return v;
      endcase
   endfunction

   function automatic logic [OW-1:0] modelJob(input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                                              input logic [N*3-1:0] op);
      int sum;
      int m;
      sum = 0;
      for (int k = 0; k < N; k++) begin
         sum += modelPre(sx6(a[k*W +: W]), int'(op[k*3 +: 3])) *
                modelPre(sx6(b[k*W +: W]), int'(op[k*3 +: 3]));
      end
      m = sum % (1 << OW);
      if (m < 0) m += (1 << OW);
      return OW'(m);
   endfunction

   task automatic clearJob();
      ja = '0;
      jb = '0;
      jo = '0;
   endtask

   task automatic setPair(input int k, input int av, input int bv, input int opv);
      ja[k*W +: W] = W'(av);
      jb[k*W +: W] = W'(bv);
      jo[k*3 +: 3] = 3'(opv);
   endtask

   // Offers the current job (called at a negedge); returns at the negedge after acceptance.
   task automatic applyStimulus(output int accEdge);
      int waited;
      exp_t e;
      in_a     = ja;
      in_b     = jb;
      op_sel   = jo;
      in_valid = 1'b1;
      waited   = 0;
      while (!in_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         reportTimeout("accept");
         accEdge  = -1;
         in_valid = 1'b0;
      end else begin
         e.res     = modelJob(ja, jb, jo);
         e.accEdge = cycleCnt + 1;
         expQ.push_back(e);
         accEdge = e.accEdge;
         @(negedge clk);
      end
   endtask

   task automatic drain();
      int waited;
      waited = 0;
      while (expQ.size() != 0 && waited < 400) begin
         @(negedge clk);
         waited++;
      end
      if (expQ.size() != 0) reportTimeout("drain");
   endtask

   // Monitor: compare each offered result, its latency, and its stability under backpressure.
   initial begin
      bit seen;
      logic [OW-1:0] held;
      seen = 1'b0;
      held = '0;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_out_valid", int'(out_valid), 0);
            end else begin
               if (!seen) begin
                  checkOutput("result", int'(out_q), int'(expQ[0].res));
                  checkOutput("latency", cycleCnt - expQ[0].accEdge, N);
                  held = out_q;
                  seen = 1'b1;
               end else begin
                  checkOutput("out_q_hold", int'(out_q), int'(held));
               end
               if (out_ready) begin
                  void'(expQ.pop_front());
                  seen = 1'b0;
               end
            end
         end else begin
            seen = 1'b0;
         end
      end
   end

   // Main sequence: directed cases first, then randomized jobs under random backpressure.
   initial begin
      int e1;
      int e2;
      int waited;
      cycleCnt    = 0;
      nChecks     = 0;
      nPassed     = 0;
      randMode    = 1'b0;
      forcedReady = 1'b1;
      in_valid    = 1'b0;
      in_a        = '0;
      in_b        = '0;
      op_sel      = '0;
      clearJob();

      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rst_out_valid", int'(out_valid), 0);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_out_q", int'(out_q), 0);
      checkOutput("rst_in_ready", int'(in_ready), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1 checkOutput("in_ready_before_edge", int'(in_ready), 0);
      @(negedge clk);
      checkOutput("in_ready_after_edge", int'(in_ready), 1);

      // All pass, a=b=1
      for (int k = 0; k < N; k++) setPair(k, 1, 1, 0);
      applyStimulus(e1);
      in_valid = 1'b0;
      drain();

      // Mixed pre-ops
      clearJob();
      setPair(2, -32, 16, 3);
      setPair(3, 1, 3, 4);
      setPair(6, 1, 3, 5);
      setPair(0, 0, 0, 1);
      checkOutput("model_mixed", int'(modelJob(ja, jb, jo)), 'h100);
      applyStimulus(e1);
      in_valid = 1'b0;
      drain();

      // Wrap cases
      for (int k = 0; k < N; k++) setPair(k, 31, 31, 0);
      applyStimulus(e1);
      in_valid = 1'b0;
      drain();
      clearJob();
      setPair(0, -32, -32, 2);
      setPair(1, 3, 5, 0);
      applyStimulus(e1);
      in_valid = 1'b0;
      drain();

      // Backpressure in DONE with in_valid toggling
      forcedReady = 1'b0;
      @(negedge clk);
      clearJob();
      for (int k = 0; k < N; k++) setPair(k, k + 1, -k, k % 8);
      applyStimulus(e1);
      in_valid = 1'b0;
      waited = 0;
      while (!out_valid && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!out_valid) reportTimeout("bp_done");
      for (int i = 0; i < 5; i++) begin
         in_valid = ~in_valid;
         checkOutput("bp_in_ready", int'(in_ready), 0);
         checkOutput("bp_busy", int'(busy), 1);
         @(negedge clk);
      end
      in_valid    = 1'b0;
      forcedReady = 1'b1;
      waited = 0;
      while (out_valid && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("bp_in_ready_after", int'(in_ready), 1);
      checkOutput("bp_no_second_job", int'(busy), 0);

      // Reset during the third RUN cycle
      clearJob();
      for (int k = 0; k < N; k++) setPair(k, 5, 7, 0);
      applyStimulus(e1);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      expQ.delete();
      checkOutput("midrst_out_valid", int'(out_valid), 0);
      checkOutput("midrst_busy", int'(busy), 0);
      checkOutput("midrst_out_q", int'(out_q), 0);
      checkOutput("midrst_in_ready", int'(in_ready), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("midrst_ready_back", int'(in_ready), 1);
      for (int k = 0; k < N; k++) setPair(k, 2, 3, 0);
      checkOutput("model_2x3", int'(modelJob(ja, jb, jo)), 48);
      applyStimulus(e1);
      in_valid = 1'b0;
      drain();

      // Back-to-back with in_valid held high
      clearJob();
      for (int k = 0; k < N; k++) setPair(k, k - 4, 3, 0);
      applyStimulus(e1);
      for (int k = 0; k < N; k++) setPair(k, -7, k, 1);
      applyStimulus(e2);
      in_valid = 1'b0;
      checkOutput("b2b_spacing", e2 - e1, N + 2);
      drain();

      // Randomized jobs and backpressure
      randMode = 1'b1;
      for (int j = 0; j < 30; j++) begin
         ja = (N*W)'({$urandom(), $urandom()});
         jb = (N*W)'({$urandom(), $urandom()});
         jo = (N*3)'($urandom());
         applyStimulus(e1);
         in_valid = 1'b0;
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      drain();
      randMode = 1'b0;
      repeat (3) @(negedge clk);

      $display("%0d/%0d checks passed", nPassed, nChecks);
      $finish;
   end

endmodule

// File: doc/mac8_seq_ctrl.md
# mac8_seq_ctrl

Sequential controller that time-shares a single signed 6×6 multiplier to compute an 8-term sum of products. Each of the 8 operand pairs has a configurable pre-operation. It accepts one job (16 operands plus per-pair op codes) over a valid/ready handshake, steps through the pairs one per cycle, and accumulates modulo 2^9. The 9-bit result is presented on a valid/ready output. It is the area-reduced, configurable alternative to the fully parallel 8-product sum block in the arithmetic benchmark family.

## Interface
- W, 6, operand width (signed)
- N, 8, number of operand pairs
- OW, 9, result width (signed)
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  job offered
- in_ready  out  1  controller can accept a job
- in_a  in  N*W  packed first operands; pair k = in_a[k*W +: W]
- in_b  in  N*W  packed second operands; pair k = in_b[k*W +: W]
- op_sel  in  N*3  packed per-pair pre-op codes; pair k = op_sel[k*3 +: 3]
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_q  out  OW  signed sum of products
- busy  out  1  high in RUN or DONE

## Operation
- FSM states are IDLE, RUN and DONE.
- **IDLE**
  - in_ready=1.
  - On in_valid&&in_ready: capture in_a, in_b and op_sel into registers, clear acc, set idx=0, go to RUN.
  - Inputs are not sampled outside acceptance.
- **RUN**
  - Each cycle, apply op_sel[idx] to both operands of pair idx, multiply, and add the product to acc.
  - idx increments each cycle. After idx=N-1 accumulates, go to DONE.
- **DONE**
  - out_valid=1 and out_q=acc, both held stable.
  - On out_ready, go to IDLE.
  - in_ready=0 in RUN and DONE. in_valid is ignored there.
- Pre-op codes apply to each operand individually, with the result truncated to W bits:
  - 0: pass
  - 1: bitwise NOT
  - 2: two's-complement negate (-32 stays -32)
  - 3: arithmetic shift right by 4
  - 4: shift left by 4
  - 5: replicate bit 0 across all W bits
  - 6, 7: pass
- Arithmetic:
  - Product is a 2W-bit signed value.
  - It is sign-extended or truncated to OW bits and added to acc modulo 2^OW.
  - No saturation and no overflow flag.
- Reset (rst_n low, any state including mid-RUN):
  - FSM goes to IDLE; acc, idx and operand registers go to 0.
  - out_valid=0, out_q=0, busy=0, in_ready=0.
  - in_ready goes to 1 on the first clk edge after rst_n deasserts.
  - Any in-flight job is discarded with no partial output.

## Timing
- Acceptance edge is T0.
- Pairs 0..N-1 accumulate on edges T1..TN.
- out_valid rises after edge TN, so latency from acceptance is N cycles (8).
- The result is consumed on the first edge with out_valid&&out_ready. in_ready=1 from the next cycle.
- Minimum job spacing is N+2 cycles (10).
- out_q is registered and changes only when entering DONE or on reset.
- There is no combinational path from in_valid or out_ready to any output except state-decoded ready and valid.

## Test plan
- **All pass:** op_sel all 0; all a=b=1. Required: q=8 exactly 8 cycles after acceptance.
- **Mixed ops, other pairs zero with pass:**
  - pair2 op3 a=-32 b=16 gives -2.
  - pair3 op4 a=1 b=3 gives 16*(-16)=-256.
  - pair6 op5 a=1 b=3 gives (-1)*(-1)=1.
  - pair0 op1 a=0 b=0 gives 1.
  - Required: q=-256 (9'h100).
- **Wrap:**
  - Case 1: all pairs pass, a=b=31, sum 7688. Required: q=8.
  - Case 2: pair0 op2 a=b=-32 (product 1024) plus pair1 pass 3*5. Required: q=15.
- **Backpressure:** hold out_ready=0 for 5 cycles in DONE while toggling in_valid. Required: out_q stable, in_ready=0, no second job taken. Then assert out_ready=1. Required: in_ready=1 the next cycle.
- **Reset mid-RUN:** assert rst_n=0 at the 3rd RUN cycle. Required: immediately out_valid=0, busy=0, out_q=0. After release, a new all-pass job with a=2, b=3 gives q=48.
- **Back-to-back:** in_valid held high with two queued jobs and out_ready=1. Required: second acceptance exactly 10 cycles after the first, and both results correct.
